// File: rtl/vu_meter_multi_if.sv
// Sample-in / LED-out bundle for the multi-channel peak meter.
interface vu_meter_multi_if #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 32,
  parameter int NUM_LEDS = 10
);
  logic [NUM_CH*DATA_W-1:0]   audio_in;
  logic                       audio_valid;
  logic                       clear_peaks;
  logic                       dot_mode;
  logic [NUM_CH*NUM_LEDS-1:0] led_out;
  logic [NUM_CH*8-1:0]        level_out;
  logic [NUM_CH-1:0]          clip_out;

  modport master (
    output audio_in, audio_valid, clear_peaks, dot_mode,
    input  led_out, level_out, clip_out
  );
  modport slave (
    input  audio_in, audio_valid, clear_peaks, dot_mode,
    output led_out, level_out, clip_out
  );
endinterface

// File: rtl/vu_meter_multi.sv
// Multi-channel peak meter: per-channel peak/decay, log bar, peak-hold dot and
// sticky clip flag; one shared free-running decay prescaler.
module vu_meter_ch #(
  parameter int DATA_W      = 32,
  parameter int NUM_LEDS    = 10,
  parameter int DECAY_SHIFT = 4,
  parameter int HOLD_TICKS  = 500,
  parameter int CLIP_TICKS  = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   i_sample,
  input  logic                i_valid,
  input  logic                i_clear,
  input  logic                i_dot,
  input  logic                i_tick,
  output logic [NUM_LEDS-1:0] o_led,
  output logic [7:0]          o_level,
  output logic                o_clip
);
  localparam int MW     = DATA_W - 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int CLIP_W = $clog2(CLIP_TICKS + 1);

  logic [MW-1:0]       w_neg, w_mag, w_shr, w_dec, r_peak;
  logic [7:0]          w_n, r_hold_lvl;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [CLIP_W-1:0]   r_clip_cnt;
  logic [NUM_LEDS-1:0] w_led, r_led;
  logic [7:0]          r_level;
  logic                r_clip;

  // Low bits negate cleanly except for the most negative code, which saturates.
  assign w_neg = ~i_sample[MW-1:0] + MW'(1);
  always_comb begin
    w_mag = i_sample[MW-1:0];
    if (i_sample[DATA_W-1])
      w_mag = (i_sample[MW-1:0] == '0) ? '1 : w_neg;
  end

  assign w_shr = r_peak >> DECAY_SHIFT;
  assign w_dec = (w_shr == '0) ? MW'(1) : w_shr;

  always_ff @(posedge clock or posedge reset)
    if (reset)                          r_peak <= '0;
    else if (i_clear)                   r_peak <= '0;
    else if (i_valid && w_mag > r_peak) r_peak <= w_mag;
    else if (i_tick)                    r_peak <= (r_peak > w_dec) ? r_peak - w_dec : '0;

  // 6 dB per LED: LED k lights at 2^(DATA_W-2-NUM_LEDS+k).
  always_comb begin
    w_n = '0;
    for (int k = 1; k <= NUM_LEDS; k++)
      if (r_peak >= (MW'(1) << (DATA_W - 2 - NUM_LEDS + k))) w_n = w_n + 8'd1;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset || i_clear) begin
      r_hold_lvl <= '0;
      r_hold_cnt <= '0;
    end else if (w_n > r_hold_lvl) begin
      r_hold_lvl <= w_n;
      r_hold_cnt <= HOLD_W'(HOLD_TICKS);
    end else if (i_tick) begin
      if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      else                  r_hold_lvl <= w_n;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset || i_clear)                r_clip_cnt <= '0;
    else if (i_valid && w_mag == '1)     r_clip_cnt <= CLIP_W'(CLIP_TICKS);
    else if (i_tick && r_clip_cnt != '0) r_clip_cnt <= r_clip_cnt - CLIP_W'(1);

  always_comb begin
    w_led = '0;
    for (int k = 0; k < NUM_LEDS; k++)
      w_led[k] = (i_dot ? (w_n == 8'(k + 1)) : (w_n >= 8'(k + 1))) ||
                 (r_hold_lvl == 8'(k + 1));
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_led   <= '0;
      r_level <= '0;
      r_clip  <= 1'b0;
    end else begin
      r_led   <= w_led;
      r_level <= w_n;
      r_clip  <= (r_clip_cnt != '0);
    end

  assign o_led   = r_led;
  assign o_level = r_level;
  assign o_clip  = r_clip;
endmodule

module vu_meter_multi #(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 32,
  parameter int NUM_LEDS    = 10,
  parameter int DECAY_TICKS = 50000,
  parameter int DECAY_SHIFT = 4,
  parameter int HOLD_TICKS  = 500,
  parameter int CLIP_TICKS  = 1000
) (
  input logic              clock,
  input logic              reset,
  vu_meter_multi_if.slave  bus
);
  localparam int DIV_W = $clog2(DECAY_TICKS + 1);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  wire  [NUM_CH-1:0][NUM_LEDS-1:0] w_led;
  wire  [NUM_CH-1:0][7:0]          w_level;
  wire  [NUM_CH-1:0]               w_clip;

  assign w_tick = (r_div == DIV_W'(DECAY_TICKS - 1));

  always_ff @(posedge clock or posedge reset)
    if (reset)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    vu_meter_ch #(
      .DATA_W(DATA_W), .NUM_LEDS(NUM_LEDS), .DECAY_SHIFT(DECAY_SHIFT),
      .HOLD_TICKS(HOLD_TICKS), .CLIP_TICKS(CLIP_TICKS)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .i_sample(bus.audio_in[g*DATA_W +: DATA_W]),
      .i_valid (bus.audio_valid),
      .i_clear (bus.clear_peaks),
      .i_dot   (bus.dot_mode),
      .i_tick  (w_tick),
      .o_led   (w_led[g]),
      .o_level (w_level[g]),
      .o_clip  (w_clip[g])
    );
  end

  assign bus.led_out   = w_led;
  assign bus.level_out = w_level;
  assign bus.clip_out  = w_clip;
endmodule

// File: tb/tb_vu_meter_multi.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge
// monitor pops and compares them. DUT B uses DECAY_SHIFT=1 for the dot/hold case.
module tb_vu_meter_multi;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] audio_in = '0;
  logic        audio_valid = 1'b0, clear_peaks = 1'b0, dot_mode = 1'b0;
  int          cyc = 0;
  int          n_tests = 0, n_fail = 0;

  typedef struct {
    int          cyc;
    bit          sel;
    logic [19:0] led;
    logic [15:0] lvl;
    logic [1:0]  clip;
    string       nm;
  } exp_t;
  exp_t sbq[$];

  vu_meter_multi_if if_a ();
  vu_meter_multi_if if_b ();

  assign if_a.audio_in = audio_in;    assign if_b.audio_in = audio_in;
  assign if_a.audio_valid = audio_valid; assign if_b.audio_valid = audio_valid;
  assign if_a.clear_peaks = clear_peaks; assign if_b.clear_peaks = clear_peaks;
  assign if_a.dot_mode = dot_mode;    assign if_b.dot_mode = dot_mode;

  vu_meter_multi #(.DECAY_TICKS(4), .DECAY_SHIFT(4), .HOLD_TICKS(3), .CLIP_TICKS(2))
    u_dut (.clock(clock), .reset(reset), .bus(if_a));
  vu_meter_multi #(.DECAY_TICKS(4), .DECAY_SHIFT(1), .HOLD_TICKS(3), .CLIP_TICKS(2))
    u_dut_b (.clock(clock), .reset(reset), .bus(if_b));

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input exp_t e);
    logic [19:0] led;
    logic [15:0] lvl;
    logic [1:0]  clip;
    led  = e.sel ? if_b.led_out   : if_a.led_out;
    lvl  = e.sel ? if_b.level_out : if_a.level_out;
    clip = e.sel ? if_b.clip_out  : if_a.clip_out;
    n_tests += 3;
    if (led !== e.led) begin
      n_fail++; $display("FAIL %s led_out @%0d: got %h want %h", e.nm, cyc, led, e.led);
    end
    if (lvl !== e.lvl) begin
      n_fail++; $display("FAIL %s level_out @%0d: got %h want %h", e.nm, cyc, lvl, e.lvl);
    end
    if (clip !== e.clip) begin
      n_fail++; $display("FAIL %s clip_out @%0d: got %b want %b", e.nm, cyc, clip, e.clip);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL %s missed: now %0d want cycle %0d", e.nm, cyc, e.cyc);
      end else check(e);
    end
  end

  task automatic push(input int c, input bit s, input logic [19:0] led,
                      input logic [15:0] lvl, input logic [1:0] clip, input string nm);
    exp_t e;
    e.cyc = c; e.sel = s; e.led = led; e.lvl = lvl; e.clip = clip; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic reset_dut();
    reset = 1'b1; audio_valid = 1'b0; clear_peaks = 1'b0; dot_mode = 1'b0; audio_in = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drv(input logic [31:0] a0, input logic [31:0] a1);
    audio_in = {a1, a0}; audio_valid = 1'b1;
    @(negedge clock);
    audio_in = '0; audio_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 1000 && cyc < c; i++) @(negedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clock);
    if (sbq.size() != 0) begin
      $display("FAIL drain: %0d expectations never reached", sbq.size());
      $fatal(1, "scoreboard stuck");
    end
  endtask

  initial begin
    // attack, decay, hold, attack on a tick cycle
    reset_dut();
    push(1, 0, 20'h00000, 16'h0000, 2'b00, "rst_state");
    push(2, 0, 20'h003FF, 16'h000A, 2'b00, "attack_full");
    drv(32'h4000_0000, 32'h0);
    push(5,  0, 20'h003FF, 16'h0009, 2'b00, "bar_drop_hold");
    push(16, 0, 20'h003FF, 16'h0009, 2'b00, "hold_last");
    push(17, 0, 20'h001FF, 16'h0009, 2'b00, "hold_follow");
    wait_until(19);
    push(21, 0, 20'h003FF, 16'h000A, 2'b00, "attack_on_tick");
    drv(32'h4000_0000, 32'h0);
    drain();

    // LED1 threshold edge, negative magnitude, hold at level 0
    reset_dut();
    push(2, 0, 20'h00001, 16'h0001, 2'b00, "lsb_thresh");
    drv(32'h0020_0000, 32'h001F_FFFF);
    push(4, 0, 20'h00401, 16'h0101, 2'b00, "neg_mag");
    push(5, 0, 20'h00401, 16'h0000, 2'b00, "hold_at_zero");
    drv(32'h0, 32'hFFE0_0000);
    drain();

    // saturation and clip expiry after two ticks
    reset_dut();
    push(2, 0, 20'hFFFFF, 16'h0A0A, 2'b01, "clip_set");
    drv(32'h8000_0000, 32'hC000_0000);
    push(8, 0, 20'hFFFFF, 16'h090A, 2'b01, "clip_hold");
    push(9, 0, 20'hFFFFF, 16'h090A, 2'b00, "clip_expire");
    drain();

    // dot mode with bar at 5 and hold at 8 (fast-decay instance)
    reset_dut();
    push(2, 1, 20'h000FF, 16'h0008, 2'b00, "b_bar8");
    drv(32'h1000_0000, 32'h0);
    push(12, 1, 20'h000BF, 16'h0006, 2'b00, "b_hold8_bar6");
    push(13, 1, 20'h00090, 16'h0005, 2'b00, "dot_hold");
    wait_until(12);
    dot_mode = 1'b1;
    wait_until(14);
    dot_mode = 1'b0;
    drain();

    // peak of 1 decays to 0 and stays there
    reset_dut();
    push(10, 0, 20'h00000, 16'h0000, 2'b00, "floor_zero");
    drv(32'h0000_0001, 32'hFFFF_FFFF);
    drain();

    // clear_peaks mid-decay, then async reset between edges
    reset_dut();
    push(6, 0, 20'hFFFFF, 16'h090A, 2'b01, "pre_clear");
    push(7, 0, 20'h00000, 16'h0000, 2'b00, "clear");
    drv(32'h8000_0000, 32'h4000_0000);
    wait_until(5);
    clear_peaks = 1'b1;
    @(negedge clock);
    clear_peaks = 1'b0;
    wait_until(8);
    push(10, 0, 20'h003FF, 16'h000A, 2'b00, "post_clear");
    drv(32'h4000_0000, 32'h0);
    drain();
    @(posedge clock);
    #2 reset = 1'b1;
    #1 push(0, 0, 20'h00000, 16'h0000, 2'b00, "async_rst");
    @(negedge clock);
    @(negedge clock);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vu_meter_multi.md
Name: vu_meter_multi

Overview:
- Parametrised multi-channel peak meter; successor to the fixed stereo 10-LED meter.
- Per channel: instant-attack peak tracking, exponential decay on a free-running tick, 6 dB/LED log bar, peak-hold dot, sticky clip flag, selectable bar/dot display.
- Sits after the audio processing chain on the same audio_valid sample strobe and drives board LEDs directly.

Parameters:
- NUM_CH, 2, number of independent channels
- DATA_W, 32, signed sample width per channel
- NUM_LEDS, 10, LEDs per channel; requires NUM_LEDS <= DATA_W-2
- DECAY_TICKS, 50000, clock cycles per decay tick (~1 ms at 50 MHz)
- DECAY_SHIFT, 4, exponential decay factor: per tick, peak loses peak>>DECAY_SHIFT
- HOLD_TICKS, 500, ticks the peak-hold dot is held
- CLIP_TICKS, 1000, ticks the clip flag stays set after the last full-scale sample

Ports:
- clock, in, 1, system clock
- reset, in, 1, asynchronous active-high reset
- audio_in, in, NUM_CH*DATA_W, signed samples; channel c occupies bits [c*DATA_W +: DATA_W]
- audio_valid, in, 1, one-cycle strobe marking all channels valid
- clear_peaks, in, 1, synchronous clear of peak, hold and clip state
- dot_mode, in, 1, 0 = bar display, 1 = single-dot display
- led_out, out, NUM_CH*NUM_LEDS, per-channel LED vector; LED k of channel c is bit c*NUM_LEDS+k-1
- level_out, out, NUM_CH*8, per-channel bar count, 0..NUM_LEDS, zero-extended
- clip_out, out, NUM_CH, per-channel clip flag

Behaviour:
- Reset is asynchronous, active-high; clock is clock. Reset zeroes all peak, hold, clip and prescaler state and all outputs.
- Magnitude is a saturating absolute value: the most negative input maps to 2^(DATA_W-1)-1, never wraps.
- Prescaler runs free and is not gated by audio_valid. It counts 0..DECAY_TICKS-1; tick is asserted for one cycle at wrap. All channels share it.
- Peak update, per channel, in priority order:
  1. clear_peaks: zero the peak.
  2. audio_valid with mag > peak: peak <= mag (attack wins over a same-cycle tick).
  3. tick: peak <= peak - max(peak>>DECAY_SHIFT, 1), floor 0.
  4. Otherwise hold.
- Bar count n = number of k in 1..NUM_LEDS with peak >= 2^(DATA_W-1-NUM_LEDS+k-1). Defaults: LED1 at 2^21, LED10 at 2^30.
- Hold state: hold_lvl and hold_cnt per channel.
  - If n > hold_lvl: hold_lvl <= n, hold_cnt <= HOLD_TICKS.
  - Else on tick: if hold_cnt > 0, decrement; otherwise hold_lvl <= n.
  - clear_peaks zeroes both.
- Clip state, per channel:
  - audio_valid with mag >= 2^(DATA_W-1)-1: clip_cnt <= CLIP_TICKS. This takes priority over a same-cycle tick.
  - tick with clip_cnt > 0: decrement.
  - clip_out = (clip_cnt != 0).
- LED pattern:
  - Bar mode: bits [n-1:0] set.
  - Dot mode: only bit n-1 set, when n > 0.
  - Both modes: bit hold_lvl-1 is also set when hold_lvl > 0.
- Outputs are registered. led_out, level_out and clip_out reflect the state updated in cycle T at cycle T+2: peak registers at T+1, outputs at T+2. Latency is fixed.
- dot_mode is sampled with the output register, so a change takes effect on the next cycle.
- Channels are fully independent; only the prescaler is shared.
- reset mid-operation takes effect immediately, including the prescaler.

Test Plan:
- Use DECAY_TICKS=4, HOLD_TICKS=3, CLIP_TICKS=2 and default widths throughout.
- Reset, then ch0 = 32'h4000_0000 valid for one cycle -> two cycles later level_out[ch0]=10, led_out ch0 = 10'h3FF; ch1 = 0, LEDs off, clip_out = 0.
- ch0 = 32'h0020_0000 (2^21) -> level_out = 1, LED bit0 only. ch0 = 32'h001F_FFFF after reset -> level_out = 0.
- ch0 = 32'h8000_0000 valid -> saturated magnitude 32'h7FFF_FFFF: level 10, clip_out[0] = 1. With no further clipping, clip_out[0] clears after exactly 2 ticks (8 cycles).
- Peak 32'h4000_0000 then silence -> peak after one tick = 32'h3C00_0000; hold bit 9 stays lit 3 ticks after the bar drops, then follows the bar. A larger sample arriving in the same cycle as a tick is loaded without decay.
- dot_mode = 1 with n = 5 and hold_lvl = 8 -> led_out = 10'b00_1001_0000. Peak at 1 with a tick -> 0, no underflow.
- clear_peaks pulse mid-decay -> led_out = 0, level_out = 0, clip_out = 0 two cycles later. Async reset asserted between clock edges -> outputs zero immediately.
